// File: rtl/key_pkg.sv
// Shared types and defaults for the key loader: FSM state encoding, key width,
// lockout threshold and the bit position of each key bit within key_out.
package key_pkg;

  localparam int KEY_W_DEF    = 5;
  localparam int MAX_FAIL_DEF = 3;

  localparam int P1_IDX = 0;
  localparam int P2_IDX = 1;
  localparam int P3_IDX = 2;
  localparam int P4_IDX = 3;
  localparam int X1_IDX = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_CHECK,
    ST_ARMED,
    ST_LOCKOUT
  } state_t;

endpackage

// File: rtl/key_loader_if.sv
// Serial key-load handshake plus key/status outputs toward the locked core.
// The master drives key_start/key_bit/key_valid; the loader is the slave.
interface key_loader_if #(
  parameter int KEY_W = key_pkg::KEY_W_DEF
);

  logic             key_start;
  logic             key_bit;
  logic             key_valid;
  logic             key_ready;
  logic [KEY_W-1:0] key_out;
  logic             key_armed;
  logic             load_err;
  logic             locked_out;

  modport master (
    output key_start, key_bit, key_valid,
    input  key_ready, key_out, key_armed, load_err, locked_out
  );

  modport slave (
    input  key_start, key_bit, key_valid,
    output key_ready, key_out, key_armed, load_err, locked_out
  );

endinterface

// File: rtl/key_shift_reg.sv
// Shadow register with bit counter; bits enter at the LSB and move left, so the
// first bit received ends up in the MSB.
module key_shift_reg #(
  parameter int SR_W  = 6,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic             i_shift,
  input  logic             i_bit,
  output logic [SR_W-1:0]  o_data,
  output logic [CNT_W-1:0] o_cnt
);

  logic [SR_W-1:0]  r_data;
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data <= '0;
      r_cnt  <= '0;
    end else if (i_clr) begin
      r_data <= '0;
      r_cnt  <= '0;
    end else if (i_shift) begin
      r_data <= {r_data[SR_W-2:0], i_bit};
      r_cnt  <= r_cnt + CNT_W'(1);
    end
  end

  assign o_data = r_data;
  assign o_cnt  = r_cnt;

endmodule

// File: rtl/key_loader.sv
// Serial key loader for the locked c432 core: shifts in a key, verifies it and
// presents it only once verified. KEY_LOADER_PARITY_EN adds a trailing even-parity
// bit, a failure counter and permanent lockout.
//
// state      | meaning
// IDLE       | waiting for key_start, key_out zero
// SHIFT      | accepting serial key bits
// CHECK      | one-cycle verification of the shadow register
// ARMED      | verified key driven to the core
// LOCKOUT    | too many failed loads; absorbing until rst
module key_loader
  import key_pkg::*;
#(
  parameter int KEY_W    = KEY_W_DEF,
  parameter int MAX_FAIL = MAX_FAIL_DEF
) (
  input logic         clk,
  input logic         rst,
  key_loader_if.slave bus
);

  localparam int CNT_W = $clog2(KEY_W + 2);
`ifdef KEY_LOADER_PARITY_EN
  localparam int REQ_BITS = KEY_W + 1;
  localparam int FAIL_W   = $clog2(MAX_FAIL + 1);
`else
  localparam int REQ_BITS = KEY_W;
`endif

  state_t           r_state;
  logic             r_key_ready;
  logic             r_key_armed;
  logic [KEY_W-1:0] r_key_out;
`ifdef KEY_LOADER_PARITY_EN
  logic [FAIL_W-1:0] r_fail_cnt;
  logic              r_load_err;
  logic              r_locked_out;
`endif

  logic [REQ_BITS-1:0] w_shadow;
  logic [CNT_W-1:0]    w_cnt;
  logic [KEY_W-1:0]    w_key;
  logic                w_pass;
  logic                w_clr;
  logic                w_shift;
  logic                w_last;

  // key_start in SHIFT restarts the load, so a coincident key_valid is dropped
  assign w_clr   = bus.key_start &&
                   (r_state == ST_IDLE || r_state == ST_SHIFT || r_state == ST_ARMED);
  assign w_shift = (r_state == ST_SHIFT) && bus.key_valid && !bus.key_start;
  assign w_last  = w_shift && (w_cnt == CNT_W'(REQ_BITS - 1));

`ifdef KEY_LOADER_PARITY_EN
  assign w_key  = w_shadow[REQ_BITS-1:1];
  assign w_pass = ~(^w_shadow);
`else
  assign w_key  = w_shadow;
  assign w_pass = 1'b1;
`endif

  key_shift_reg #(
    .SR_W  (REQ_BITS),
    .CNT_W (CNT_W)
  ) u_shift_reg (
    .clk     (clk),
    .rst     (rst),
    .i_clr   (w_clr),
    .i_shift (w_shift),
    .i_bit   (bus.key_bit),
    .o_data  (w_shadow),
    .o_cnt   (w_cnt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_key_ready <= 1'b0;
      r_key_armed <= 1'b0;
      r_key_out   <= '0;
`ifdef KEY_LOADER_PARITY_EN
      r_fail_cnt   <= '0;
      r_load_err   <= 1'b0;
      r_locked_out <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.key_start) begin
            r_state     <= ST_SHIFT;
            r_key_ready <= 1'b1;
`ifdef KEY_LOADER_PARITY_EN
            r_load_err  <= 1'b0;
`endif
          end
        end
        ST_SHIFT: begin
          // ready drops with the last bit so no extra bit can be accepted
          if (w_last) begin
            r_state     <= ST_CHECK;
            r_key_ready <= 1'b0;
          end
        end
        ST_CHECK: begin
          if (w_pass) begin
            r_state     <= ST_ARMED;
            r_key_out   <= w_key;
            r_key_armed <= 1'b1;
`ifdef KEY_LOADER_PARITY_EN
            r_fail_cnt  <= '0;
`endif
          end else begin
`ifdef KEY_LOADER_PARITY_EN
            r_load_err <= 1'b1;
            r_fail_cnt <= r_fail_cnt + FAIL_W'(1);
            if (r_fail_cnt == FAIL_W'(MAX_FAIL - 1)) begin
              r_state      <= ST_LOCKOUT;
              r_locked_out <= 1'b1;
            end else begin
              r_state <= ST_IDLE;
            end
`else
            r_state <= ST_IDLE;
`endif
          end
        end
        ST_ARMED: begin
          if (bus.key_start) begin
            r_state     <= ST_SHIFT;
            r_key_ready <= 1'b1;
            r_key_armed <= 1'b0;
            r_key_out   <= '0;
          end
        end
        ST_LOCKOUT: begin
          r_key_ready <= 1'b0;
          r_key_armed <= 1'b0;
          r_key_out   <= '0;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.key_ready = r_key_ready;
  assign bus.key_armed = r_key_armed;
  assign bus.key_out   = r_key_out;
`ifdef KEY_LOADER_PARITY_EN
  assign bus.load_err   = r_load_err;
  assign bus.locked_out = r_locked_out;
`else
  assign bus.load_err   = 1'b0;
  assign bus.locked_out = 1'b0;
`endif

endmodule

// File: tb/tb_key_loader.sv
// Directed bench for key_loader; covers the default build and, when
// KEY_LOADER_PARITY_EN is defined, the parity/lockout build.
module tb_key_loader;
  import key_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  key_loader_if #(.KEY_W(KEY_W_DEF)) kif ();

  key_loader #(
    .KEY_W    (KEY_W_DEF),
    .MAX_FAIL (MAX_FAIL_DEF)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (kif.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start();
    kif.key_start = 1'b1;
    tick();
    kif.key_start = 1'b0;
  endtask

  task automatic send_bit(input logic b, input int gap);
    repeat (gap) tick();
    kif.key_valid = 1'b1;
    kif.key_bit   = b;
    tick();
    kif.key_valid = 1'b0;
    kif.key_bit   = 1'b0;
  endtask

  task automatic send_word(input logic [7:0] w, input int nb, input int gap);
    for (int i = nb - 1; i >= 0; i--) send_bit(w[i], gap);
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    #1;
    chk("rst_async_ready", 32'(kif.key_ready), 32'd0);
    chk("rst_async_out",   32'(kif.key_out),   32'd0);
    chk("rst_async_armed", 32'(kif.key_armed), 32'd0);
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    kif.key_start = 1'b0;
    kif.key_bit   = 1'b0;
    kif.key_valid = 1'b0;
    tick();
    tick();
    chk("reset_ready",  32'(kif.key_ready),  32'd0);
    chk("reset_out",    32'(kif.key_out),    32'd0);
    chk("reset_armed",  32'(kif.key_armed),  32'd0);
    chk("reset_err",    32'(kif.load_err),   32'd0);
    chk("reset_locked", 32'(kif.locked_out), 32'd0);
    rst = 1'b0;
    tick();

`ifdef KEY_LOADER_PARITY_EN
    // good load: 10110 + parity 1
    start();
    chk("p_ready_shift", 32'(kif.key_ready), 32'd1);
    send_word(8'b101101, 6, 0);
    chk("p_armed_lat1", 32'(kif.key_armed), 32'd0);
    tick();
    chk("p_armed_lat2", 32'(kif.key_armed), 32'd1);
    chk("p_key_10110",  32'(kif.key_out),   32'b10110);
    chk("p_err_good",   32'(kif.load_err),  32'd0);

    // reload from ARMED with 00011 + parity 0
    start();
    chk("p_rearm_armed", 32'(kif.key_armed), 32'd0);
    chk("p_rearm_out",   32'(kif.key_out),   32'd0);
    send_word(8'b000110, 6, 0);
    tick();
    chk("p_key_00011", 32'(kif.key_out), 32'b00011);

    // three bad-parity loads lead to lockout
    for (int n = 1; n <= 3; n++) begin
      start();
      chk("p_err_clear", 32'(kif.load_err), 32'd0);
      send_word(8'b101100, 6, 0);
      tick();
      chk("p_bad_err",    32'(kif.load_err),   32'd1);
      chk("p_bad_armed",  32'(kif.key_armed),  32'd0);
      chk("p_bad_out",    32'(kif.key_out),    32'd0);
      chk("p_bad_locked", 32'(kif.locked_out), (n == 3) ? 32'd1 : 32'd0);
      tick();
      chk("p_bad_ready",  32'(kif.key_ready),  32'd0);
    end
    start();
    chk("p_lock_ready",  32'(kif.key_ready),  32'd0);
    chk("p_lock_locked", 32'(kif.locked_out), 32'd1);

    pulse_rst();
    chk("p_rst_locked", 32'(kif.locked_out), 32'd0);

    // reset mid-shift then valid load with gaps
    start();
    send_word(8'b101, 3, 0);
    pulse_rst();
    start();
    send_word(8'b101101, 6, 2);
    tick();
    chk("p_after_rst_key",   32'(kif.key_out),   32'b10110);
    chk("p_after_rst_armed", 32'(kif.key_armed), 32'd1);

    // fail counter was cleared: two more bad loads do not lock out
    for (int n = 0; n < 2; n++) begin
      start();
      send_word(8'b101100, 6, 0);
      tick();
    end
    chk("p_two_bad_locked", 32'(kif.locked_out), 32'd0);
    chk("p_two_bad_err",    32'(kif.load_err),   32'd1);
`else
    // load 11111, two-clock latency to armed
    start();
    chk("ready_shift", 32'(kif.key_ready), 32'd1);
    send_word(8'b11111, 5, 0);
    chk("ready_drop",  32'(kif.key_ready), 32'd0);
    chk("armed_lat1",  32'(kif.key_armed), 32'd0);
    chk("out_lat1",    32'(kif.key_out),   32'd0);
    tick();
    chk("armed_lat2",  32'(kif.key_armed),  32'd1);
    chk("key_11111",   32'(kif.key_out),    32'b11111);
    chk("err_tied",    32'(kif.load_err),   32'd0);
    chk("locked_tied", 32'(kif.locked_out), 32'd0);

    // re-entry from ARMED drops key immediately; load with 2-cycle gaps
    start();
    chk("rearm_armed", 32'(kif.key_armed), 32'd0);
    chk("rearm_out",   32'(kif.key_out),   32'd0);
    chk("rearm_ready", 32'(kif.key_ready), 32'd1);
    send_word(8'b10110, 5, 2);
    chk("gap_armed_lat1", 32'(kif.key_armed), 32'd0);
    tick();
    chk("key_10110_gaps", 32'(kif.key_out),   32'b10110);
    chk("gap_armed",      32'(kif.key_armed), 32'd1);

    // restart mid-shift
    start();
    send_bit(1'b1, 0);
    send_bit(1'b1, 0);
    start();
    chk("restart_ready", 32'(kif.key_ready), 32'd1);
    chk("restart_armed", 32'(kif.key_armed), 32'd0);
    send_word(8'b00011, 5, 0);
    tick();
    chk("key_00011", 32'(kif.key_out), 32'b00011);

    // reset after 3 of 5 bits, then a full load
    start();
    send_word(8'b101, 3, 0);
    pulse_rst();
    start();
    send_word(8'b01001, 5, 0);
    chk("post_rst_lat1", 32'(kif.key_armed), 32'd0);
    tick();
    chk("key_01001",       32'(kif.key_out),   32'b01001);
    chk("post_rst_armed",  32'(kif.key_armed), 32'd1);

    // stray bits while ARMED are ignored
    send_bit(1'b0, 0);
    send_bit(1'b1, 0);
    chk("armed_hold_out",   32'(kif.key_out),   32'b01001);
    chk("armed_hold_ready", 32'(kif.key_ready), 32'd0);
    chk("x1_bit", 32'(kif.key_out[X1_IDX]), 32'd0);
    chk("p1_bit", 32'(kif.key_out[P1_IDX]), 32'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/key_loader.md
KEY_LOADER -- requirements
Module: key_loader

Interface
REQ-001 Parameter KEY_W, default 5: number of key bits delivered to the locked c432 core, ordered {X_1,p4,p3,p2,p1} MSB..LSB.
REQ-002 Parameter MAX_FAIL, default 3: consecutive failed loads before permanent lockout.
REQ-003 Ports SHALL be as follows; the design has one clock, and reset is asynchronous and active-high:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous active-high reset.
- key_start  input  1  single-cycle pulse that begins a load.
- key_bit  input  1  serial key data, MSB first.
- key_valid  input  1  key_bit qualifier.
- key_ready  output  1  loader accepts key_bit this cycle.
- key_out  output  KEY_W  key to the core: p1=key_out[0] .. X_1=key_out[4].
- key_armed  output  1  key_out holds a verified key.
- load_err  output  1  last load failed its check.
- locked_out  output  1  MAX_FAIL reached; no further loads accepted.

Function
REQ-004 The FSM SHALL have the states IDLE, SHIFT, CHECK, ARMED and LOCKOUT.
REQ-005 IDLE: key_ready=0; key_start moves to SHIFT, clears the bit counter and the shadow register, and clears load_err.
REQ-006 SHIFT: key_ready=1; each cycle with key_valid=1 shifts key_bit into the shadow register LSB (left shift) and increments the counter; cycles with key_valid=0 hold all state.
REQ-007 After the last required bit is accepted, the FSM SHALL enter CHECK on the next clock; the required count is KEY_W, or KEY_W+1 with parity enabled.
REQ-008 CHECK lasts exactly one cycle with key_ready=0; on pass, shadow is copied to key_out, key_armed=1, the fail counter clears, and the FSM goes to ARMED.
REQ-009 On fail, load_err=1 and the fail counter increments; if the counter reaches MAX_FAIL the FSM goes to LOCKOUT, otherwise to IDLE; key_out stays zero and key_armed=0.
REQ-010 ARMED: key_out and key_armed hold; key_start re-enters SHIFT, key_armed drops to 0 and key_out returns to zero in that same cycle, so no partial key ever reaches the core.
REQ-011 key_start while in SHIFT SHALL restart the load (counter and shadow cleared); this is not counted as a failure.
REQ-012 LOCKOUT is absorbing until rst: locked_out=1, key_out=0, key_armed=0, and key_start is ignored.
REQ-013 key_out SHALL be zero whenever key_armed=0.
REQ-014 Latency from the final accepted bit to key_armed=1 SHALL be 2 clocks.
REQ-015 The bit counter SHALL be ceil(log2(KEY_W+2)) bits wide and SHALL never wrap; bits presented beyond the required count are impossible because key_ready drops.

Reset
REQ-016 rst asserted SHALL immediately force: FSM=IDLE, key_ready=0, key_out=0, key_armed=0, load_err=0, locked_out=0, fail counter=0, shadow=0.
REQ-017 rst asserted mid-SHIFT SHALL discard the partial key, with no fail count.

Configuration
REQ-018 With KEY_LOADER_PARITY_EN defined, one trailing even-parity bit follows the key, and CHECK passes only if the XOR of all KEY_W+1 bits is 0.
REQ-019 Without KEY_LOADER_PARITY_EN, exactly KEY_W bits are shifted, CHECK always passes, and load_err and locked_out are tied to 0.

Structure
REQ-020 A shared package key_pkg SHALL hold the FSM state enum, KEY_W and MAX_FAIL defaults, and the key bit-index constants (P1_IDX=0 .. X1_IDX=4).
REQ-021 One sub-module, key_shift_reg (shadow register plus counter), SHALL be used; the FSM and the fail counter live in key_loader.

Verification
REQ-022 Parity enabled: key_start, then bits 1,0,1,1,0 and parity 1 -> key_out=5'b10110 and key_armed=1 two clocks after the last bit.
REQ-023 Parity enabled: bits 1,0,1,1,0 with parity 0 -> load_err=1, key_armed=0, key_out=0, FSM back in IDLE.
REQ-024 Three consecutive bad-parity loads -> locked_out=1; a fourth key_start leaves key_ready=0.
REQ-025 Armed with 5'b10110, then key_start -> key_armed=0 and key_out=0 in the same cycle; load 5'b00011 (parity 0) -> key_out=5'b00011.
REQ-026 rst pulsed after 3 of 5 bits, then a full valid load -> correct key, fail counter 0; key_valid gaps of 2 cycles do not corrupt data.
REQ-027 Parity disabled: 5 bits 11111 -> key_out=5'b11111 after 2 clocks, load_err constant 0.
